// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared types and timing defaults for the WS2812 frame serializer
package ws2812_pkg;

  localparam int PIX_W    = 24;
  localparam int BIT_W    = $clog2(PIX_W);
  localparam int DEF_T0H  = 32;
  localparam int DEF_T1H  = 64;
  localparam int DEF_TBIT = 100;
  localparam int DEF_TRST = 24000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } state_e;

  // One counter width serves both the bit period and the latch gap.
  function automatic int cnt_width(input int tbit, input int trst);
    int m;
    m = (tbit > trst) ? tbit : trst;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ws2812_frame_tx_if.sv
// rtl/ws2812_frame_tx_if.sv - synchronous pixel RAM read port (1-cycle latency)
interface ws2812_frame_tx_if #(
  parameter int ADDR_W = 6
) ();
  import ws2812_pkg::*;

  logic              rd_en_out;
  logic [ADDR_W-1:0] rd_addr_out;
  logic [PIX_W-1:0]  rd_data_in;

  modport master (output rd_en_out, output rd_addr_out, input rd_data_in);
  modport slave  (input rd_en_out, input rd_addr_out, output rd_data_in);
endinterface

// File: rtl/ws2812_bit_gen.sv
// rtl/ws2812_bit_gen.sv - one NRZ bit period: high for T0H/T1H cycles, then low to TBIT
module ws2812_bit_gen #(
  parameter int T0H   = 32,
  parameter int T1H   = 64,
  parameter int TBIT  = 100,
  parameter int CNT_W = 7
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic bit_i,
  output logic pulse_o,
  output logic bit_done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] HI0  = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] HI1  = CNT_W'(T1H);

  logic             active_q, active_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign bit_done_o = active_q && (cnt_q == LAST);
  assign pulse_o    = pulse_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  // The line is registered; every bit starts high, so the bit value is only
  // needed from the second cycle on, when the shift register already holds it.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      pulse_d  = 1'b1;
    end else if (active_q) begin
      if (cnt_q == LAST) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d   = cnt_inc;
        pulse_d = cnt_inc < (bit_i ? HI1 : HI0);
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_tx.sv
// rtl/ws2812_frame_tx.sv - fetches NUM_PIXELS GRB words and emits them as WS2812 NRZ, then the latch gap
module ws2812_frame_tx
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS = 64,
  parameter int ADDR_W     = 6,
  parameter int T0H        = DEF_T0H,
  parameter int T1H        = DEF_T1H,
  parameter int TBIT       = DEF_TBIT,
  parameter int TRST       = DEF_TRST
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              frame_rdy_in,
  ws2812_frame_tx_if.master ram,
  output logic              busy_out,
  output logic              done_out,
  output logic              ws2812_data_out
);

  localparam int CNT_W = cnt_width(TBIT, TRST);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(TRST - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [PIX_W-1:0]  sr_q, sr_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              pending_q, pending_d;

  logic bg_start, bg_done, gap_last;

  assign gap_last        = (gap_cnt_q == GAP_LAST);
  assign ram.rd_addr_out = idx_q;

  ws2812_bit_gen #(
    .T0H   (T0H),
    .T1H   (T1H),
    .TBIT  (TBIT),
    .CNT_W (CNT_W)
  ) u_bit_gen (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .start_i    (bg_start),
    .bit_i      (sr_q[PIX_W-1]),
    .pulse_o    (ws2812_data_out),
    .bit_done_o (bg_done)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pending_d = pending_q;

    // Start requests while busy collapse into one; a request on the last gap
    // cycle is consumed directly by the restart below.
    if (state_q == ST_GAP && gap_last) begin
      pending_d = 1'b0;
    end else if (frame_rdy_in && state_q != ST_IDLE) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_rdy_in) begin
          state_d = ST_FETCH;
          idx_d   = '0;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        sr_d      = ram.rd_data_in;
        bit_cnt_d = BIT_W'(PIX_W - 1);
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (bg_done) begin
          sr_d = {sr_q[PIX_W-2:0], 1'b0};
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
          end else if (idx_q == LAST_IDX) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          gap_cnt_d = '0;
          if (pending_q || frame_rdy_in) begin
            idx_d   = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram.rd_en_out = (state_q == ST_FETCH);
    busy_out      = (state_q != ST_IDLE);
    done_out      = (state_q == ST_GAP) && gap_last;
    bg_start      = (state_q == ST_LOAD) ||
                    ((state_q == ST_SEND) && bg_done && (bit_cnt_q != '0));
  end

endmodule
